// File: rtl/local_op_sequencer.sv
// Nibble-serial front end for the local map-algebra operator: loads a 4-nibble
// command, holds operands for EXEC_WAIT cycles, then streams back M and N.
module local_op_sequencer #(
  parameter int EXEC_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [3:0] op_c,
  output logic [3:0] op_d,
  input  logic [3:0] res_m,
  input  logic [3:0] res_n,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic [7:0] frame_count
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    EXEC   = 2'd1,
    SEND_M = 2'd2,
    SEND_N = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic [3:0] n_cap;
  logic       accept;
  logic       send_hs;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      LOAD: begin
        in_ready = ~rst;
        busy     = 1'b0;
        if (in_valid && (idx == 2'd3)) begin
          state_nxt = EXEC;
        end else begin
          state_nxt = LOAD;
        end
      end
      EXEC: begin
        if (cnt == LAST_CNT) begin
          state_nxt = SEND_M;
        end else begin
          state_nxt = EXEC;
        end
      end
      SEND_M: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = SEND_N;
        end else begin
          state_nxt = SEND_M;
        end
      end
      SEND_N: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = SEND_N;
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign send_hs = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      idx         <= 2'd0;
      cnt         <= 4'd0;
      op_a        <= 4'd0;
      op_b        <= 4'd0;
      op_c        <= 4'd0;
      op_d        <= 4'd0;
      n_cap       <= 4'd0;
      out_data    <= 4'd0;
      out_last    <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          if (accept) begin
            case (idx)
              2'd0:    op_a <= in_data;
              2'd1:    op_b <= in_data;
              2'd2:    op_c <= in_data;
              default: op_d <= in_data;
            endcase
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              cnt <= 4'd0;
            end
          end
        end
        EXEC: begin
          cnt <= cnt + 4'd1;
          // M goes straight into the output register; N waits for the M handshake.
          if (cnt == LAST_CNT) begin
            out_data <= res_m;
            n_cap    <= res_n;
            out_last <= 1'b0;
          end
        end
        SEND_M: begin
          if (send_hs) begin
            out_data <= n_cap;
            out_last <= 1'b1;
          end
        end
        SEND_N: begin
          if (send_hs) begin
            out_last    <= 1'b0;
            frame_count <= frame_count + 8'd1;
          end
        end
        default: begin
          idx <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/local_op_sequencer.md
Name: local_op_sequencer

Overview:
- Nibble-serial front end for the local map-algebra operator.
- Accepts a 4-nibble command frame (A, B, C, D) over a valid/ready input stream and holds the operands stable on dedicated operand outputs that drive the combinational two-stage local operator.
- After a configurable settle time, captures the operator's M and N results and streams them back out as a 2-nibble frame over a valid/ready output stream.
- It is the initiator/driver side of the operator interface and sits between the tile pins and the operator.

Parameters:
- EXEC_WAIT, 1, number of cycles operands are held before results are sampled. Legal range 1..15; 4-bit counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_data  input  4  command nibble; frame order A, B, C, D (D[3:2]=op1, D[1:0]=op2)
- in_valid  input  1  in_data valid
- in_ready  output  1  sequencer can accept a nibble
- op_a  output  4  operand A to operator
- op_b  output  4  operand B to operator
- op_c  output  4  operand C to operator
- op_d  output  4  opcode D to operator
- res_m  input  4  operator result M = A op1 B (low 4 bits)
- res_n  input  4  operator result N = M op2 C (low 4 bits)
- out_data  output  4  result nibble; M first, then N
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_last  output  1  high with the N nibble (last of frame)
- busy  output  1  high in any state other than LOAD
- frame_count  output  8  completed frames, wraps 255->0

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst is synchronous and active-high; sampled only on the rising edge of clk.
- Reset values:
  - state=LOAD, nibble index=0, wait counter=0.
  - op_a/op_b/op_c/op_d=0, captured M/N=0, out_data=0, frame_count=0.
  - out_valid=0, out_last=0, busy=0.
  - in_ready=0 while rst is high, otherwise follows the state.
- Handshakes:
  - A transfer occurs on an edge where valid and ready are both 1.
  - Producer data and valid must be held until accepted.
- LOAD:
  - in_ready=1.
  - Each accepted nibble is written to op_a, op_b, op_c, op_d in turn, by nibble index 0..3.
  - Operand registers update at the accepting edge and are otherwise held.
  - Accepting index 3 (D) moves to EXEC, clears the wait counter and resets the index to 0.
  - in_valid=0 leaves all state unchanged; idle gaps between nibbles are allowed.
- EXEC:
  - in_ready=0, busy=1; operands held constant.
  - The counter increments each cycle.
  - On the cycle the counter equals EXEC_WAIT-1, res_m and res_n are registered into the M/N capture registers and the state moves to SEND_M.
  - Net effect: the state lasts exactly EXEC_WAIT cycles.
- SEND_M:
  - out_valid=1, out_data=captured M, out_last=0.
  - Stays here until out_ready=1, then moves to SEND_N.
- SEND_N:
  - out_valid=1, out_data=captured N, out_last=1.
  - On handshake: frame_count increments (modulo 256), state returns to LOAD.
- Latency:
  - D is accepted at edge t; out_valid rises in the cycle after edge t+EXEC_WAIT.
  - With EXEC_WAIT=1 this is 2 cycles from D acceptance to first result nibble.
  - Minimum frame period with no stalls: 4 + EXEC_WAIT + 2 cycles.
- Output stability:
  - out_data and out_last are registered and do not change while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
- No overlap: a new command frame is not accepted until the N nibble has been handshaken. in_ready=0 throughout EXEC/SEND_M/SEND_N.
- Operand retention: op_a..op_d keep the last frame's values through output and into the next LOAD, until each is overwritten by its own nibble.
- out_ready held high in LOAD/EXEC has no effect.
- Reset mid-frame (any state): all registers return to reset values on that edge; partial frames are discarded; no output nibble is emitted afterward.
- Width rules: captured results are the 4-bit values presented by the operator; no internal arithmetic other than the counters.

Test Plan:
- Reset, then frame A=3, B=5, C=2, D=4'b1001 (add, or), EXEC_WAIT=1, out_ready=1 -> op_a..op_d=3,5,2,9. Out nibbles are 4'h8 (out_last=0) then 4'hA (out_last=1). out_valid rises 2 cycles after D accepted. frame_count=1.
- Frame A=3, B=5, C=6, D=4'b1100 (mul, and) with out_ready=0 for 5 cycles -> out_valid stays 1 with out_data=4'hF stable. After out_ready=1, nibbles F then 6. in_ready=0 throughout the stall.
- in_valid toggling 1,0,1,0 between nibbles of frame A=15, B=1, C=15, D=4'b1011 (add, mul) -> ignored gaps. Results M=0, N=0 (wrap-around from operator). busy=0 only in LOAD.
- EXEC_WAIT=4, frame A=2, B=3, C=1, D=4'b1110 -> exactly 4 EXEC cycles with stable operands. M=6, N=7 emitted; first out_valid 5 cycles after D accepted.
- Assert rst during SEND_M of a frame -> next cycle out_valid=0, op_*=0, frame_count=0, in_ready=1. A following clean frame produces correct results.
- Run 256 back-to-back frames -> frame_count wraps 255->0. No nibble is dropped or duplicated; out_last is set on every second output handshake only.
